// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the start/byte-stream/instruction-memory-write
// signals of the instruction-memory loader.
//   start, in_valid, in_data : host -> loader (session start, byte stream)
//   in_ready                 : loader -> host (byte accepted this cycle)
//   WE, W_Addr, W_Ins        : loader -> instruction memory (registered)
//   cpu_rst, busy, done, err : loader status
//   dbg_state                : loader FSM state, for observation only
// Handshake: a byte transfers on a posedge where in_valid && in_ready are
// both 1; in_data is ignored on every other edge, and a held in_valid with
// in_ready low simply waits.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        WE;
  logic [31:0] W_Addr;
  logic [31:0] W_Ins;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, WE, W_Addr, W_Ins, cpu_rst, busy, done, err, dbg_state
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, WE, W_Addr, W_Ins, cpu_rst, busy, done, err, dbg_state
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed big-endian byte stream and writes
// it word by word into instruction memory, holding the CPU in reset until
// the load completes.
// Ports:
//   CLK       : sole clock, all state on posedge
//   RST       : synchronous active-high reset
//   bus       : imem_loader_if.slave (stream in, memory write out, status)
// Stream format: N[15:8], N[7:0], then 4*N bytes, each word MSB first.
// Words with index >= IMEM_SIZE are consumed but not written, and err is set.
module imem_loader #(
  parameter int IMEM_SIZE = 64
) (
  input  logic        CLK,
  input  logic        RST,
  imem_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [15:0] k_q, k_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wins_q, wins_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic in_ready_w;
  logic accept;

  assign in_ready_w = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA);
  assign accept     = bus.in_valid && in_ready_w;

  assign bus.in_ready  = in_ready_w;
  assign bus.busy      = in_ready_w || (state_q == S_WRITE);
  // The CPU leaves reset only once the image is complete.
  assign bus.cpu_rst   = (state_q != S_DONE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.WE        = we_q;
  assign bus.W_Addr    = waddr_q;
  assign bus.W_Ins     = wins_q;
  assign bus.dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    k_d     = k_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wins_d  = wins_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          k_d     = 16'd0;
          bcnt_d  = 2'd0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = {len_q[15:8], bus.in_data};
          err_d = (32'(len_d) > 32'(IMEM_SIZE));
          if (len_d == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], bus.in_data};
          bcnt_d = bcnt_q + 2'd1;
          // Load the write registers together with the last byte so that
          // WE, W_Addr and W_Ins are valid during the WRITE cycle itself.
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = (32'(k_q) < 32'(IMEM_SIZE));
            waddr_d = {14'd0, k_q, 2'b00};
            wins_d  = word_d;
          end
        end
      end
      S_WRITE: begin
        k_d = k_q + 16'd1;
        if (k_d == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      word_q  <= 32'd0;
      bcnt_q  <= 2'd0;
      k_q     <= 16'd0;
      we_q    <= 1'b0;
      waddr_q <= 32'd0;
      wins_q  <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      k_q     <= k_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wins_q  <= wins_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader (IMEM_SIZE = 64).
// Expected memory writes are queued as words are driven and popped by a
// monitor on every WE pulse.
module tb_imem_loader;

  localparam int IMEM_SIZE = 64;

  logic clk;
  logic rst;

  imem_loader_if bus ();

  imem_loader #(.IMEM_SIZE(IMEM_SIZE)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {W_Addr, W_Ins}
  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int tb_k = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.WE === 1'b1) begin
      logic [63:0] e;
      we_cnt++;
      check("in_ready_in_write", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", bus.W_Addr, e[63:32]);
        check("w_ins", bus.W_Ins, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and return just after a posedge.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit rdy;
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      t++;
    end while (!rdy && t < 50);
    if (!rdy) check("byte_timeout", 32'd0, 32'd1);
    #1 bus.in_valid = 1'b0;
    bus.in_data = $urandom_range(0, 255);   // must be ignored
    if (stall) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    bit wr;
    wr = (tb_k < IMEM_SIZE);
    if (wr) exp_q.push_back({32'(tb_k * 4), w});
    send_byte(w[31:24], stall);
    send_byte(w[23:16], stall);
    send_byte(w[15:8], stall);
    send_byte(w[7:0], 1'b0);
    @(negedge clk);
    check("we_latency", 32'(bus.WE), 32'(wr));
    @(posedge clk);
    #1;
    tb_k++;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (bus.done !== 1'b1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.WE), 32'd0);
    check({tag, "_w_addr"}, bus.W_Addr, 32'd0);
    check({tag, "_w_ins"}, bus.W_Ins, 32'd0);
    check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we_base;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("rst0");

    // Two-word load, back to back.
    tb_k = 0;
    do_start();
    @(negedge clk);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_cpu_rst_busy", 32'(bus.cpu_rst), 32'd1);
    @(posedge clk);
    #1;
    send_len(16'h0002);
    send_word(32'h3C010010, 1'b0);
    send_word(32'h00000000, 1'b0);
    wait_done();
    @(negedge clk);
    check("t1_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("t1_err", 32'(bus.err), 32'd0);
    check("t1_we_cnt", 32'(we_cnt), 32'd2);
    @(posedge clk);
    #1;

    // Zero-length load.
    we_base = we_cnt;
    tb_k = 0;
    do_start();
    @(negedge clk);
    check("t2_done_cleared", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("t2_cpu_rst_lenlo", 32'(bus.cpu_rst), 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("t2_cpu_rst_fall", 32'(bus.cpu_rst), 32'd0);
    check("t2_done", 32'(bus.done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_no_we", 32'(we_cnt - we_base), 32'd0);

    // Oversized load: 65 words, last one suppressed.
    we_base = we_cnt;
    tb_k = 0;
    do_start();
    send_len(16'h0041);
    @(negedge clk);
    check("t3_err_early", 32'(bus.err), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 65; i++) send_word($urandom(), 1'b0);
    wait_done();
    check("t3_we_cnt", 32'(we_cnt - we_base), 32'd64);
    check("t3_err", 32'(bus.err), 32'd1);

    // Restart from DONE clears status; stalled single-word load.
    we_base = we_cnt;
    tb_k = 0;
    do_start();
    @(negedge clk);
    check("t4_done_clr", 32'(bus.done), 32'd0);
    check("t4_err_clr", 32'(bus.err), 32'd0);
    check("t4_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    @(posedge clk);
    #1;
    send_len(16'h0001);
    send_word(32'h12345678, 1'b1);
    wait_done();
    check("t4_we_cnt", 32'(we_cnt - we_base), 32'd1);

    // Reset in the middle of a word, with a byte offered in the same cycle.
    tb_k = 0;
    do_start();
    send_len(16'h0002);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_outputs("rst_mid");
    we_base = we_cnt;
    tb_k = 0;
    do_start();
    send_len(16'h0001);
    send_word(32'hAABBCCDD, 1'b0);
    wait_done();
    check("t5_we_cnt", 32'(we_cnt - we_base), 32'd1);

    // start during DATA must be ignored.
    we_base = we_cnt;
    tb_k = 0;
    do_start();
    send_len(16'h0002);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'hCA, 1'b0);
    do_start();
    @(negedge clk);
    check("t6_busy_after_start", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    tb_k = 1;
    exp_q.push_back({32'd4, 32'hCAFE0123});
    tb_k = 2;   // expectation already queued; bypass send_word for this word
    send_byte(8'hFE, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    wait_done();
    check("t6_we_cnt", 32'(we_cnt - we_base), 32'd2);

    repeat (4) @(posedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
